// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the RV32I pipeline.
// Handles stall, redirect/squash, ECALL halt and misaligned redirect detection.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_target_pc,
    input  logic        i_halt_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_ifid_inst,
    output logic [31:0] o_ifid_pc,
    output logic [31:0] o_ifid_pc4,
    output logic        o_ifid_valid,
    output logic        o_halted,
    output logic        o_misalign_err
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_inst;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic        r_halted;
    logic        r_misalign_err;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= RUN;
            r_pc           <= RESET_PC;
            r_ifid_inst    <= NOP_INST;
            r_ifid_pc      <= 32'd0;
            r_ifid_pc4     <= 32'd0;
            r_ifid_valid   <= 1'b0;
            r_halted       <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    // A redirect squashes a wrong-path ECALL and beats any stall.
                    if (i_redirect) begin
                        r_pc         <= {i_target_pc[31:2], 2'b00};
                        r_ifid_inst  <= NOP_INST;
                        r_ifid_valid <= 1'b0;
                        if (i_target_pc[1:0] != 2'b00) begin
                            r_misalign_err <= 1'b1;
                        end
                    end else if (i_halt_req) begin
                        r_ifid_inst  <= NOP_INST;
                        r_ifid_valid <= 1'b0;
                        r_halted     <= 1'b1;
                        r_state      <= HALT;
                    end else if (!i_stall) begin
                        r_pc         <= w_pc_plus4;
                        r_ifid_inst  <= i_imem_rdata;
                        r_ifid_pc    <= r_pc;
                        r_ifid_pc4   <= w_pc_plus4;
                        r_ifid_valid <= 1'b1;
                    end
                end
                HALT: begin
                    r_ifid_inst  <= NOP_INST;
                    r_ifid_valid <= 1'b0;
                    r_halted     <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign o_imem_addr    = r_pc;
    assign o_ifid_inst    = r_ifid_inst;
    assign o_ifid_pc      = r_ifid_pc;
    assign o_ifid_pc4     = r_ifid_pc4;
    assign o_ifid_valid   = r_ifid_valid;
    assign o_halted       = r_halted;
    assign o_misalign_err = r_misalign_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed steps push expected state into a
// queue, a negedge monitor pops and compares against the DUT.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] targetPc;
    logic        haltReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic [31:0] ifidInst;
    logic [31:0] ifidPc;
    logic [31:0] ifidPc4;
    logic        ifidValid;
    logic        halted;
    logic        misalignErr;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] ipc;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic        mis;
        logic        cmpPc;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_target_pc   (targetPc),
        .i_halt_req    (haltReq),
        .o_imem_addr   (imemAddr),
        .i_imem_rdata  (imemRdata),
        .o_ifid_inst   (ifidInst),
        .o_ifid_pc     (ifidPc),
        .o_ifid_pc4    (ifidPc4),
        .o_ifid_valid  (ifidValid),
        .o_halted      (halted),
        .o_misalign_err(misalignErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: two real words, everything else a recognisable pattern.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0000: memWord = 32'h0050_0093;
            32'h0000_0004: memWord = 32'h0010_0113;
            default:       memWord = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    always_comb imemRdata = memWord(imemAddr);

    task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                 input logic [31:0] t, input logic h);
        rst      = r;
        stall    = s;
        redirect = rd;
        targetPc = t;
        haltReq  = h;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string n, input logic [31:0] p, input logic [31:0] i,
                               input logic [31:0] ip, input logic [31:0] p4, input logic v,
                               input logic hl, input logic m, input logic c);
        exp_t e;
        e.name = n; e.pc = p; e.inst = i; e.ipc = ip; e.pc4 = p4;
        e.valid = v; e.halted = hl; e.mis = m; e.cmpPc = c;
        expQ.push_back(e);
    endtask

    // Monitor: the DUT presents a new IF/ID state every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            exp_t e;
            logic bad;
            e = expQ.pop_front();
            bad = (imemAddr !== e.pc) || (ifidInst !== e.inst) || (ifidValid !== e.valid) ||
                  (halted !== e.halted) || (misalignErr !== e.mis) ||
                  (e.cmpPc && ((ifidPc !== e.ipc) || (ifidPc4 !== e.pc4)));
            checks++;
            if (bad) begin
                errors++;
                $display("[TB] FAIL %s: got pc=%h inst=%h ipc=%h pc4=%h v=%b h=%b m=%b, want pc=%h inst=%h ipc=%h pc4=%h v=%b h=%b m=%b (pcs checked=%b)",
                         e.name, imemAddr, ifidInst, ifidPc, ifidPc4, ifidValid, halted, misalignErr,
                         e.pc, e.inst, e.ipc, e.pc4, e.valid, e.halted, e.mis, e.cmpPc);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; targetPc = 32'd0; haltReq = 1'b0;
        @(negedge clk);

        applyStimulus(1, 0, 0, 32'h0, 0);
        checkOutput("reset1", 32'h0, 32'h13, 32'h0, 32'h0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 32'h0, 0);
        checkOutput("reset2", 32'h0, 32'h13, 32'h0, 32'h0, 0, 0, 0, 1);

        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("fetch0", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("fetch4", 32'h8, 32'h0010_0113, 32'h4, 32'h8, 1, 0, 0, 1);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 32'h0, 0);
            checkOutput("stallHold", 32'h8, 32'h0010_0113, 32'h4, 32'h8, 1, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("afterStall", 32'hC, memWord(32'h8), 32'h8, 32'hC, 1, 0, 0, 1);

        applyStimulus(0, 1, 1, 32'h40, 0);
        checkOutput("redirOverStall", 32'h40, 32'h13, 32'h0, 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("fetch40", 32'h44, memWord(32'h40), 32'h40, 32'h44, 1, 0, 0, 1);

        applyStimulus(0, 0, 1, 32'h20, 0);
        checkOutput("redir20", 32'h20, 32'h13, 32'h0, 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 32'h0, 1);
        checkOutput("haltOverStall", 32'h20, 32'h13, 32'h0, 32'h0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 32'h80, 0);
        checkOutput("haltIgnRedir", 32'h20, 32'h13, 32'h0, 32'h0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 32'h82, 0);
        checkOutput("haltIgnMisalign", 32'h20, 32'h13, 32'h0, 32'h0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("haltFrozen", 32'h20, 32'h13, 32'h0, 32'h0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 32'h0, 0);
        checkOutput("resetFromHalt", 32'h0, 32'h13, 32'h0, 32'h0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("refetch0", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 0, 0, 1);

        applyStimulus(0, 0, 1, 32'h100, 1);
        checkOutput("redirOverHalt", 32'h100, 32'h13, 32'h0, 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("fetch100", 32'h104, memWord(32'h100), 32'h100, 32'h104, 1, 0, 0, 1);
        applyStimulus(0, 0, 1, 32'h102, 0);
        checkOutput("misalignRedir", 32'h100, 32'h13, 32'h0, 32'h0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("misalignSticky", 32'h104, memWord(32'h100), 32'h100, 32'h104, 1, 0, 1, 1);

        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0);
        checkOutput("redirTop", 32'hFFFF_FFFC, 32'h13, 32'h0, 32'h0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("wrap", 32'h0, memWord(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("afterWrap", 32'h4, 32'h0050_0093, 32'h0, 32'h4, 1, 0, 1, 1);
        applyStimulus(1, 0, 0, 32'h0, 0);
        checkOutput("resetClearsMis", 32'h0, 32'h13, 32'h0, 32'h0, 0, 0, 0, 1);

        rst = 1'b0;
        repeat (3) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left in scoreboard, want 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
